// File: rtl/vliw_pkg.sv
// rtl/vliw_pkg.sv - shared opcodes, lane record and NOP lane helper for the decode stage
package vliw_pkg;

   localparam logic [3:0] OP_NOP  = 4'd0;
   localparam logic [3:0] OP_LOAD = 4'd1;
   localparam logic [3:0] REG0    = 4'd0;

   localparam int LANE_OP_W   = 4;
   localparam int LANE_REG_W  = 4;
   localparam int LANE_DATA_W = 64;

   typedef struct packed {
      logic [LANE_OP_W-1:0]   inst;
      logic [LANE_REG_W-1:0]  dest;
      logic [LANE_DATA_W-1:0] data;
   } lane_t;

   // A lane that does nothing: no opcode, writes REG0, carries no data.
   function automatic lane_t nop_lane();
      lane_t l;
      l.inst = OP_NOP;
      l.dest = REG0;
      l.data = '0;
      return l;
   endfunction

endpackage

// File: rtl/vliw_lane_sanitise.sv
// rtl/vliw_lane_sanitise.sv - per-bundle opcode/dest/data cleanup and intra-bundle WAW squash
module vliw_lane_sanitise
   import vliw_pkg::*;
#(
   parameter int NUM_LANES = 3,
   parameter int OP_W      = 4,
   parameter int REG_W     = 4,
   parameter int DATA_W    = 64
) (
   input  logic [NUM_LANES*OP_W-1:0]   raw_inst,
   input  logic [NUM_LANES*REG_W-1:0]  raw_dest,
   input  logic [NUM_LANES*DATA_W-1:0] raw_data,
   output logic [NUM_LANES*OP_W-1:0]   clean_inst,
   output logic [NUM_LANES*REG_W-1:0]  clean_dest,
   output logic [NUM_LANES*DATA_W-1:0] clean_data,
   output logic [NUM_LANES-1:0]        squash
);

   localparam logic [OP_W-1:0]  NOP_OP  = OP_W'(OP_NOP);
   localparam logic [OP_W-1:0]  LOAD_OP = OP_W'(OP_LOAD);
   localparam logic [REG_W-1:0] R0      = REG_W'(REG0);

   logic [OP_W-1:0]   op  [NUM_LANES];
   logic [REG_W-1:0]  dst [NUM_LANES];
   logic [DATA_W-1:0] dat [NUM_LANES];
   logic [NUM_LANES-1:0] lane_kill;

   // Lane 0 lives in the most significant slice of every bus.
   for (genvar g = 0; g < NUM_LANES; g++) begin : g_unpack
      assign op[g]  = raw_inst[(NUM_LANES-1-g)*OP_W   +: OP_W];
      assign dst[g] = raw_dest[(NUM_LANES-1-g)*REG_W  +: REG_W];
      assign dat[g] = raw_data[(NUM_LANES-1-g)*DATA_W +: DATA_W];
   end

   // A lane dies if any later lane writes the same real register; decided on original opcodes.
   always_comb begin
      lane_kill = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         for (int j = i + 1; j < NUM_LANES; j++) begin
            if (op[i] != NOP_OP && op[j] != NOP_OP && dst[i] != R0 && dst[i] == dst[j])
               lane_kill[i] = 1'b1;
         end
      end
   end

   for (genvar g = 0; g < NUM_LANES; g++) begin : g_pack
      assign clean_inst[(NUM_LANES-1-g)*OP_W +: OP_W] = lane_kill[g] ? NOP_OP : op[g];
      assign clean_dest[(NUM_LANES-1-g)*REG_W +: REG_W] =
         (lane_kill[g] || op[g] == NOP_OP) ? R0 : dst[g];
      assign clean_data[(NUM_LANES-1-g)*DATA_W +: DATA_W] =
         (!lane_kill[g] && op[g] == LOAD_OP) ? dat[g] : '0;
      assign squash[NUM_LANES-1-g] = lane_kill[g];
   end

endmodule

// File: rtl/vliw_decode_stage.sv
// rtl/vliw_decode_stage.sv - decode stage with output register, skid buffer, flush and statistics
module vliw_decode_stage
   import vliw_pkg::*;
#(
   parameter int NUM_LANES = 3,
   parameter int OP_W      = 4,
   parameter int REG_W     = 4,
   parameter int DATA_W    = 64,
   parameter int CNT_W     = 32
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        flush,
   input  logic                        f2d_valid,
   output logic                        d2f_ready,
   input  logic [NUM_LANES*OP_W-1:0]   f2d_inst,
   input  logic [NUM_LANES*REG_W-1:0]  f2d_dest,
   input  logic [NUM_LANES*DATA_W-1:0] f2d_data,
   output logic                        d2e_valid,
   input  logic                        e2d_ready,
   output logic [NUM_LANES*OP_W-1:0]   d2e_inst,
   output logic [NUM_LANES*REG_W-1:0]  d2e_dest,
   output logic [NUM_LANES*DATA_W-1:0] d2e_data,
   output logic [NUM_LANES-1:0]        d2e_squash,
   output logic [CNT_W-1:0]            stat_bundles,
   output logic [CNT_W-1:0]            stat_squashes
);

   localparam logic [NUM_LANES*OP_W-1:0]  NOP_INST = {NUM_LANES{OP_W'(OP_NOP)}};
   localparam logic [NUM_LANES*REG_W-1:0] NOP_DEST = {NUM_LANES{REG_W'(REG0)}};

   logic [NUM_LANES*OP_W-1:0]   new_inst;
   logic [NUM_LANES*REG_W-1:0]  new_dest;
   logic [NUM_LANES*DATA_W-1:0] new_data;
   logic [NUM_LANES-1:0]        new_squash;

   logic [NUM_LANES*OP_W-1:0]   skid_inst;
   logic [NUM_LANES*REG_W-1:0]  skid_dest;
   logic [NUM_LANES*DATA_W-1:0] skid_data;
   logic [NUM_LANES-1:0]        skid_squash;
   logic                        skid_full;

   logic             accept;
   logic             xfer;
   logic [CNT_W-1:0] sq_count;

   vliw_lane_sanitise #(
      .NUM_LANES (NUM_LANES),
      .OP_W      (OP_W),
      .REG_W     (REG_W),
      .DATA_W    (DATA_W)
   ) u_sanitise (
      .raw_inst   (f2d_inst),
      .raw_dest   (f2d_dest),
      .raw_data   (f2d_data),
      .clean_inst (new_inst),
      .clean_dest (new_dest),
      .clean_data (new_data),
      .squash     (new_squash)
   );

   assign accept = f2d_valid & d2f_ready;
   assign xfer   = d2e_valid & e2d_ready;

   // Number of squashed lanes in the bundle currently on the output.
   always_comb begin
      sq_count = '0;
      for (int k = 0; k < NUM_LANES; k++)
         sq_count = sq_count + CNT_W'(d2e_squash[k]);
   end

   // Output register and skid buffer; flush overrides everything, the skid drains before new input.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         d2e_valid   <= 1'b0;
         d2e_inst    <= NOP_INST;
         d2e_dest    <= NOP_DEST;
         d2e_data    <= '0;
         d2e_squash  <= '0;
         skid_full   <= 1'b0;
         skid_inst   <= NOP_INST;
         skid_dest   <= NOP_DEST;
         skid_data   <= '0;
         skid_squash <= '0;
         d2f_ready   <= 1'b1;
      end else if (flush) begin
         d2e_valid  <= 1'b0;
         d2e_inst   <= NOP_INST;
         d2e_dest   <= NOP_DEST;
         d2e_data   <= '0;
         d2e_squash <= '0;
         skid_full  <= 1'b0;
         d2f_ready  <= 1'b1;
      end else if (!d2e_valid || e2d_ready) begin
         if (skid_full) begin
            d2e_valid  <= 1'b1;
            d2e_inst   <= skid_inst;
            d2e_dest   <= skid_dest;
            d2e_data   <= skid_data;
            d2e_squash <= skid_squash;
            skid_full  <= 1'b0;
            d2f_ready  <= 1'b1;
         end else if (accept) begin
            d2e_valid  <= 1'b1;
            d2e_inst   <= new_inst;
            d2e_dest   <= new_dest;
            d2e_data   <= new_data;
            d2e_squash <= new_squash;
         end else begin
            d2e_valid  <= 1'b0;
            d2e_inst   <= NOP_INST;
            d2e_dest   <= NOP_DEST;
            d2e_data   <= '0;
            d2e_squash <= '0;
         end
      end else if (accept) begin
         skid_full   <= 1'b1;
         skid_inst   <= new_inst;
         skid_dest   <= new_dest;
         skid_data   <= new_data;
         skid_squash <= new_squash;
         d2f_ready   <= 1'b0;
      end
   end

   // Delivery statistics; a transfer in a flush cycle was still seen by execute.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_bundles  <= '0;
         stat_squashes <= '0;
      end else if (xfer) begin
         stat_bundles  <= stat_bundles + CNT_W'(1);
         stat_squashes <= stat_squashes + sq_count;
      end
   end

endmodule
